// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester-side byte handshake bundle for uart_tx_arbiter
//
// Purpose: groups the N_REQ byte sources' valid/data/ready signals.
// Signals:
//   req_valid [N_REQ]    requester i has a byte pending
//   req_data  [8*N_REQ]  byte of requester i at bits [8i+7:8i]
//   req_ready [N_REQ]    one-hot acceptance strobe from the arbiter
// Modports:
//   master  byte producers (drive valid/data, observe ready)
//   slave   arbiter (observe valid/data, drive ready)
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one 8N1 transmitter among N_REQ byte sources
//
// Purpose: grants one requester at a time, latches its byte and launches
// the frame on the transmitter; waits for busy to fall plus IDLE_GAP clocks
// before the next grant.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   req          requester bundle (slave side): req_valid, req_data, req_ready
//   tx_send_req  frame launch request to the transmitter
//   tx_data      byte for the transmitter, held for the whole frame
//   tx_busy      transmitter busy flag
//   active       high from grant until the end of the inter-frame gap
//   active_id    index of the current or last granted requester
//   frame_done   one-cycle pulse when the arbiter first sees busy low
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int IDLE_GAP = 0,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_arbiter_if.slave req,
  output logic            tx_send_req,
  output logic [7:0]      tx_data,
  input  logic            tx_busy,
  output logic            active,
  output logic [ID_W-1:0] active_id,
  output logic            frame_done
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_END, GAP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [7:0]      gap_cnt;
  logic [ID_W-1:0] winner;
  logic            any_valid;
  logic            grant;
  int              idx;

  // Scan from the highest offset down so the requester closest to rr_ptr
  // (in rotating order) is the one left in winner.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req.req_valid[idx[ID_W-1:0]]) begin
        winner    = idx[ID_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  // reset is folded in so the combinational ready stays low while held in reset.
  assign grant = reset && (state == IDLE) && !tx_busy && any_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant)    state_nxt = LAUNCH;
      LAUNCH:   if (tx_busy)  state_nxt = WAIT_END;
      WAIT_END: if (!tx_busy) state_nxt = (IDLE_GAP == 0) ? IDLE : GAP;
      GAP:      if (gap_cnt <= 8'd1) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req.req_ready = '0;
    if (grant) req.req_ready[winner] = 1'b1;
    frame_done = (state == WAIT_END) && !tx_busy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_send_req <= 1'b0;
      tx_data     <= 8'h00;
      active      <= 1'b0;
      active_id   <= '0;
      rr_ptr      <= '0;
      gap_cnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data     <= req.req_data[8*winner +: 8];
            active_id   <= winner;
            rr_ptr      <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            active      <= 1'b1;
            tx_send_req <= 1'b1;
          end
        end
        LAUNCH: begin
          if (tx_busy) tx_send_req <= 1'b0;
        end
        WAIT_END: begin
          if (!tx_busy) begin
            if (IDLE_GAP == 0) active  <= 1'b0;
            else               gap_cnt <= 8'(IDLE_GAP);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt <= 8'd1) active <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
